// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS-R2000 fetch pipeline.
// Holds the prefetch queue entry layout and reset/vector addresses.
package mips_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Pointers carry one extra wrap bit; head is read straight from storage.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           wdata,
    input  logic                   pop,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer update; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with prefetch queue and redirect flush.
// Requests are credit-limited so the queue can never overflow.
module fetch_prefetch_unit #(
    parameter int              XLEN       = mips_pkg::XLEN,
    parameter int              DEPTH      = 4,
    parameter int              MAX_OUTST  = 2,
    parameter logic [XLEN-1:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [XLEN-1:0] EXC_VECTOR = mips_pkg::EXC_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_pc,
    input  logic            hold_if,
    input  logic            br,
    input  logic [XLEN-1:0] pc_branch,
    input  logic            except,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out
);

    import mips_pkg::*;

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 2;
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [AW:0]     outst;
    logic [AW:0]     outst_next;
    logic [AW:0]     discard;
    logic [AW:0]     q_count;
    logic [CW-1:0]   inflight;
    logic            q_full;
    logic            q_empty;
    logic            redirect;
    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;
    fetch_entry_t    wentry;
    fetch_entry_t    head;

    assign redirect = except | br;
    assign target   = except ? EXC_VECTOR
                             : (pc_branch & ~XLEN'(3));

    assign inflight = CW'(q_count) + CW'(outst);

    // A stray response with nothing outstanding is ignored.
    assign resp   = imem_rvalid && (outst != '0);
    assign accept = imem_req && imem_ready;
    assign push   = resp && (discard == '0) && !redirect;
    assign pop    = if_valid && !hold_if;
    assign wentry = '{pc: resp_pc, inst: imem_rdata};

    assign imem_addr = fetch_pc;

    // Issue gate: slot limit plus queue credit.
    always_comb begin
        imem_req = 1'b0;
        if (!rst && !hold_pc && !redirect &&
            (outst < (AW+1)'(MAX_OUTST)) &&
            (inflight < CW'(DEPTH)) && !q_full)
            imem_req = 1'b1;
    end

    // Outstanding count after this cycle's accept and response.
    always_comb begin
        outst_next = outst;
        if (accept) outst_next = outst_next + ONE;
        if (resp)   outst_next = outst_next - ONE;
    end

    // Head presentation; empty queue shows a NOP at PC 0.
    always_comb begin
        if_valid = !q_empty;
        pc_out   = '0;
        inst_out = NOP_INST;
        if (!q_empty) begin
            pc_out   = head.pc;
            inst_out = head.inst;
        end
    end

    // Fetch PC, response PC and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else begin
            outst <= outst_next;
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= outst_next;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (push)
                    resp_pc <= resp_pc + XLEN'(4);
                if (resp && (discard != '0))
                    discard <= discard - ONE;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

endmodule
